// File: rtl/izh_neuron_array.sv
// Time-multiplexed array of Izhikevich neurons: one shared saturating fixed-point
// datapath visits every neuron once per step request and streams spike events.
module izh_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 18,
  parameter int DT_SHIFT  = 2,
  parameter int U_SHIFT   = 4,
  localparam int ID_W     = ($clog2(N_NEURONS) > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [ID_W-1:0]      cfg_addr,
  input  logic [WIDTH-1:0]     cfg_data,
  output logic                 busy,
  output logic                 done,
  output logic                 spike_valid,
  output logic [ID_W-1:0]      spike_id,
  output logic [WIDTH-1:0]     v_out,
  output logic [ID_W-1:0]      v_id,
  output logic [N_NEURONS-1:0] spike_mask
);
  localparam int F  = WIDTH - 2;
  localparam int XW = WIDTH + 3;

  // num/den rounded to nearest at F fractional bits, integer-only
  function automatic logic signed [WIDTH-1:0] fx(input longint num, input longint den);
    longint mag;
    mag = (((num < 0) ? -num : num) <<< (F + 1)) + den;
    mag = mag / (2 * den);
    return WIDTH'((num < 0) ? -mag : mag);
  endfunction

  function automatic logic signed [XW-1:0] sxt(input logic signed [WIDTH-1:0] x);
    return {{(XW-WIDTH){x[WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] x);
    if (&x[XW-1:WIDTH-1] || ~|x[XW-1:WIDTH-1]) return x[WIDTH-1:0];
    return x[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  localparam logic signed [WIDTH-1:0] V_RST = fx(-70, 100);
  localparam logic signed [WIDTH-1:0] U_RST = fx(-20, 100);
  localparam logic signed [WIDTH-1:0] VPEAK = fx(30, 100);
  localparam logic signed [WIDTH-1:0] K_I14 = fx(140, 100) >>> 2;
  localparam logic signed [WIDTH-1:0] C_065 = fx(-65, 100);
  localparam logic signed [WIDTH-1:0] C_055 = fx(-55, 100);
  localparam logic signed [WIDTH-1:0] C_050 = fx(-50, 100);
  localparam logic signed [WIDTH-1:0] D_080 = fx(8, 100);
  localparam logic signed [WIDTH-1:0] D_040 = fx(4, 100);
  localparam logic signed [WIDTH-1:0] D_020 = fx(2, 100);
  localparam logic signed [WIDTH-1:0] D_005 = fx(5, 1000);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                           state_q;
  logic [ID_W-1:0]                  idx_q;
  logic [N_NEURONS-1:0][WIDTH-1:0]  v_q, u_q, i_q;
  logic [N_NEURONS-1:0][2:0]        mode_q;
  logic [N_NEURONS-1:0]             acc_q, mask_q;
  logic                             busy_q, done_q, spk_v_q;
  logic [ID_W-1:0]                  spk_id_q, v_id_q;
  logic [WIDTH-1:0]                 v_out_q;

  logic [2:0]                       a_sh, b_sh;
  logic signed [WIDTH-1:0]          c_k, d_k, v_r, u_r, i_r, sq, v_d, u_d;
  logic signed [2*WIDTH-1:0]        vw, p;
  logic signed [XW-1:0]             vx, ux, ix, dv, du;
  logic                             fire, unused_p;
  logic [N_NEURONS-1:0]             fire_bits;

  always_comb begin
    a_sh = 3'd5; b_sh = 3'd2; c_k = C_065; d_k = D_080;
    case (mode_q[idx_q])
      3'd1: begin c_k = C_055; d_k = D_040; end
      3'd2: begin c_k = C_050; d_k = D_020; end
      3'd3: begin a_sh = 3'd3; b_sh = 3'd1; d_k = D_020; end
      3'd4: begin b_sh = 3'd1; d_k = D_005; end
      3'd5: begin a_sh = 3'd3; b_sh = 3'd1; d_k = D_020; end
      3'd6: begin b_sh = 3'd1; d_k = D_020; end
      default: ;
    endcase
  end

  always_comb begin
    v_r = v_q[idx_q];
    u_r = u_q[idx_q];
    i_r = i_q[idx_q];
    vx  = sxt(v_r);
    ux  = sxt(u_r);
    ix  = sxt(i_r);
    vw  = {{WIDTH{v_r[WIDTH-1]}}, v_r};
    p   = vw * vw;
    // v^2 back in Q2.F: keep the product sign, drop the extra integer bits
    sq  = {p[2*WIDTH-1], p[F+WIDTH-2:F]};
    unused_p = ^{p[2*WIDTH-2:F+WIDTH-1], p[F-1:0]};
    dv  = sxt(sq) + vx + (vx >>> 2) + sxt(K_I14) - (ux >>> 2) + (ix >>> 2);
    du  = ((vx >>> b_sh) - ux) >>> a_sh;
    fire = v_r > VPEAK;
    v_d = fire ? c_k : sat(vx + (dv >>> DT_SHIFT));
    u_d = fire ? sat(ux + sxt(d_k)) : sat(ux + (du >>> U_SHIFT));
    fire_bits = '0;
    fire_bits[idx_q] = fire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      mask_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      spk_v_q  <= 1'b0;
      spk_id_q <= '0;
      v_id_q   <= '0;
      v_out_q  <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_q[k]    <= V_RST;
        u_q[k]    <= U_RST;
        i_q[k]    <= '0;
        mode_q[k] <= '0;
      end
    end else begin
      done_q  <= 1'b0;
      spk_v_q <= 1'b0;
      // config lands at the edge, so a same-cycle update still sees the old value
      if (cfg_we) begin
        if (cfg_sel) mode_q[cfg_addr] <= cfg_data[2:0];
        else         i_q[cfg_addr]    <= cfg_data;
      end
      case (state_q)
        S_IDLE: if (step) begin
          state_q <= S_RUN;
          idx_q   <= '0;
          acc_q   <= '0;
          busy_q  <= 1'b1;
        end
        S_RUN: begin
          v_q[idx_q] <= v_d;
          u_q[idx_q] <= u_d;
          v_out_q    <= v_d;
          v_id_q     <= idx_q;
          spk_v_q    <= fire;
          if (fire) spk_id_q <= idx_q;
          if (idx_q == ID_W'(N_NEURONS - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            mask_q  <= acc_q | fire_bits;
          end else begin
            idx_q <= idx_q + ID_W'(1);
            acc_q <= acc_q | fire_bits;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign spike_valid = spk_v_q;
  assign spike_id    = spk_id_q;
  assign v_out       = v_out_q;
  assign v_id        = v_id_q;
  assign spike_mask  = mask_q;
endmodule

// File: tb/tb_izh_neuron_array.sv
// Directed bench for izh_neuron_array (N=4, WIDTH=18): hand-derived constants
// plus an integer reference model of the neuron equations.
module tb_izh_neuron_array;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n, step, cfg_we, cfg_sel;
  logic [1:0]  cfg_addr;
  logic [17:0] cfg_data;
  logic        busy, done, spike_valid;
  logic [1:0]  spike_id, v_id;
  logic [17:0] v_out;
  logic [3:0]  spike_mask;

  izh_neuron_array #(.N_NEURONS(4), .WIDTH(18), .DT_SHIFT(2), .U_SHIFT(4)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy), .done(done),
    .spike_valid(spike_valid), .spike_id(spike_id), .v_out(v_out), .v_id(v_id),
    .spike_mask(spike_mask)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // mode table in raw Q2.16 integers
  int MC[8] = '{-42598, -36045, -32768, -42598, -42598, -42598, -42598, -42598};
  int MD[8] = '{5243, 2621, 1311, 1311, 328, 1311, 1311, 5243};
  int MA[8] = '{5, 5, 5, 3, 5, 3, 5, 5};
  int MB[8] = '{2, 2, 2, 1, 1, 1, 1, 2};

  longint mv[N], mu[N], mi[N];
  int     mmode[N];
  logic [17:0] obs_v[N];
  bit          obs_spk[N];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic longint clamp(input longint x);
    if (x > 131071) return 131071;
    if (x < -131072) return -131072;
    return x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = -45875; mu[k] = -13107; mi[k] = 0; mmode[k] = 0;
    end
  endtask

  task automatic model_upd(input int k, output longint vo, output bit f);
    longint v, u, i, p, sq, dv, du;
    int m;
    v = mv[k]; u = mu[k]; i = mi[k]; m = mmode[k];
    if (v > 19661) begin
      f = 1'b1;
      mv[k] = MC[m];
      mu[k] = clamp(u + MD[m]);
    end else begin
      f  = 1'b0;
      p  = v * v;
      sq = (p >>> 16) % 131072;
      dv = sq + v + (v >>> 2) + 22937 - (u >>> 2) + (i >>> 2);
      du = ((v >>> MB[m]) - u) >>> MA[m];
      mv[k] = clamp(v + (dv >>> 2));
      mu[k] = clamp(u + (du >>> 4));
    end
    vo = mv[k] & 64'h3FFFF;
  endtask

  task automatic cfg(input bit sel, input int addr, input longint d);
    logic [17:0] dd;
    dd = d[17:0];
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr[1:0]; cfg_data = dd;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (sel) mmode[addr] = int'(d & 7);
    else     mi[addr] = d;
  endtask

  // one full step; glitch re-pulses step mid-run, which must be ignored
  task automatic run_step(input bit glitch);
    longint ev[N];
    bit     mf[N];
    logic [3:0] mmask;
    mmask = '0;
    for (int k = 0; k < N; k++) begin
      model_upd(k, ev[k], mf[k]);
      mmask[k] = mf[k];
    end
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    for (int c = 1; c <= N + 2; c++) begin
      @(posedge clk); #1;
      chk("done", done, (c == N) ? 1 : 0);
      if (c <= N) begin
        chk("busy_run", busy, 1);
        chk("v_id", v_id, c - 1);
        chk("v_out", v_out, ev[c-1]);
        chk("spike_valid", spike_valid, mf[c-1]);
        if (spike_valid) chk("spike_id", spike_id, c - 1);
        obs_v[c-1]   = v_out;
        obs_spk[c-1] = spike_valid;
      end else begin
        chk("busy_idle", busy, 0);
        chk("spike_mask", spike_mask, mmask);
      end
      if (glitch && c == 1) step = 1'b1;
      if (c == 2) step = 1'b0;
    end
  endtask

  initial begin
    bit f0, f1, f2, sat_seen;
    int s3, bad, spk;
    rst_n = 1'b0; step = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0;
    cfg_addr = '0; cfg_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_spk", spike_valid, 0);
    chk("rst_spk_id", spike_id, 0);
    chk("rst_v_out", v_out, 0);
    chk("rst_v_id", v_id, 0);
    chk("rst_mask", spike_mask, 0);
    rst_n = 1'b1;
    model_reset();

    // readback of reset state, with an ignored step pulse mid-run
    run_step(1'b1);
    for (int k = 0; k < N; k++) chk("first_v", obs_v[k], 18'h34DC2);

    // spiking: n2 mode 0, n1 mode 2, n0 mode 7, n3 stays at I=0
    cfg(1'b0, 2, 65536);
    cfg(1'b0, 1, 65536);
    cfg(1'b1, 1, 2);
    cfg(1'b0, 0, 65536);
    cfg(1'b1, 0, 7);
    f0 = 0; f1 = 0; f2 = 0; s3 = 0;
    for (int s = 0; s < 200 && !(f0 && f1 && f2); s++) begin
      run_step(1'b0);
      if (obs_spk[2] && !f2) begin
        f2 = 1;
        chk("fire2_v", obs_v[2], 18'h3599A);
        chk("fire2_mask", spike_mask[2], 1);
      end
      if (obs_spk[1] && !f1) begin
        f1 = 1;
        chk("fire1_mode2_v", obs_v[1], 18'h38000);
      end
      if (obs_spk[0] && !f0) begin
        f0 = 1;
        chk("fire0_mode7_v", obs_v[0], 18'h3599A);
      end
      if (obs_spk[3]) s3++;
    end
    chk("fired_all", {f0, f1, f2}, 3'b111);
    chk("n3_quiet", s3, 0);

    // saturation: pump u up with max current, then drive the most-negative current
    cfg(1'b0, 3, 131071);
    repeat (300) run_step(1'b0);
    cfg(1'b0, 3, -131072);
    sat_seen = 0; bad = 0; spk = 0;
    repeat (80) begin
      run_step(1'b0);
      if (sat_seen && obs_v[3] != 18'h20000) bad++;
      if (sat_seen && obs_spk[3]) spk++;
      if (obs_v[3] == 18'h20000) sat_seen = 1;
    end
    chk("sat_reached", sat_seen, 1);
    chk("sat_hold", bad, 0);
    chk("sat_no_spike", spk, 0);

    // abort: reset while idx=1
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_v_out", v_out, 0);
    chk("abort_mask", spike_mask, 0);
    @(posedge clk); #1;
    chk("abort_done2", done, 0);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("abort_idle_done", done, 0);
    run_step(1'b0);
    for (int k = 0; k < N; k++) chk("post_abort_v", obs_v[k], 18'h34DC2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
